// File: rtl/moldudp64_rx_parser_pkg.sv
// Shared types and protocol constants for the MoldUDP64 receive parser.
package moldudp64_rx_parser_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StEthHdr,
        StIpHdr,
        StUdpHdr,
        StMoldHdr,
        StLenHi,
        StLenLo,
        StMsgBody,
        StDrain
    } rx_parser_state_t;

    localparam logic [5:0] ETH_HDR_LEN  = 6'd14;
    localparam logic [5:0] IP_HDR_LEN   = 6'd20;
    localparam logic [5:0] UDP_HDR_LEN  = 6'd8;
    localparam logic [5:0] MOLD_HDR_LEN = 6'd20;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] MOLD_EOS_CNT   = 16'hFFFF;

endpackage

// File: rtl/moldudp64_rx_parser.sv
// Walks Ethernet/IPv4/UDP/MoldUDP64 headers and splits the payload into
// sequence-tagged messages; non-matching or short frames bump the drop counter.
module moldudp64_rx_parser
    import moldudp64_rx_parser_pkg::*;
#(
    parameter logic [15:0] UDP_PORT = 16'd26400,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic [7:0]       dataIn,
    input  logic             dataValidIn,
    input  logic             dataLastIn,
    output logic [7:0]       msgDataOut,
    output logic             msgValidOut,
    output logic             msgStartOut,
    output logic             msgEndOut,
    output logic             msgErrOut,
    output logic [63:0]      seqNumOut,
    output logic             seqGapOut,
    output logic             eosOut,
    output logic [CNT_W-1:0] dropCntOut
);

    rx_parser_state_t stateQ, stateD;
    logic [5:0]       byteCntQ, byteCntD;
    logic [63:0]      seqShQ, seqShD;
    logic [7:0]       fieldHiQ, fieldHiD;
    logic [63:0]      expSeqQ, expSeqD;
    logic             expValidQ, expValidD;
    logic [63:0]      curSeqQ, curSeqD;
    logic [15:0]      msgRemainQ, msgRemainD;
    logic [15:0]      bodyRemQ, bodyRemD;
    logic             firstQ, firstD;
    logic             msgSeenQ, msgSeenD;

    logic [7:0]       msgDataQ, msgDataD;
    logic             msgValidQ, msgValidD;
    logic             msgStartQ, msgStartD;
    logic             msgEndQ, msgEndD;
    logic             msgErrQ, msgErrD;
    logic [63:0]      seqNumQ, seqNumD;
    logic             seqGapQ, seqGapD;
    logic             eosQ, eosD;
    logic [CNT_W-1:0] dropCntQ, dropCntD;

    logic [5:0]  hdrIdx;
    logic [15:0] fieldWord;
    logic [15:0] remainDec;
    logic        doDrop;

    // The byte that wakes the parser from idle is Ethernet byte 0.
    assign hdrIdx    = (stateQ == StIdle) ? 6'd0 : byteCntQ;
    assign fieldWord = {fieldHiQ, dataIn};
    assign remainDec = msgRemainQ - 16'd1;

    always_comb begin
        stateD     = stateQ;
        byteCntD   = byteCntQ;
        seqShD     = seqShQ;
        fieldHiD   = fieldHiQ;
        expSeqD    = expSeqQ;
        expValidD  = expValidQ;
        curSeqD    = curSeqQ;
        msgRemainD = msgRemainQ;
        bodyRemD   = bodyRemQ;
        firstD     = firstQ;
        msgSeenD   = msgSeenQ;
        msgDataD   = msgDataQ;
        msgValidD  = 1'b0;
        msgStartD  = 1'b0;
        msgEndD    = 1'b0;
        msgErrD    = 1'b0;
        seqNumD    = seqNumQ;
        seqGapD    = 1'b0;
        eosD       = 1'b0;
        dropCntD   = dropCntQ;
        doDrop     = 1'b0;

        if (dataValidIn) begin
            unique case (stateQ)
                StIdle, StEthHdr: begin
                    stateD   = StEthHdr;
                    byteCntD = hdrIdx + 6'd1;
                    if ((hdrIdx == 6'd12 && dataIn != ETHERTYPE_IPV4[15:8]) ||
                        (hdrIdx == 6'd13 && dataIn != ETHERTYPE_IPV4[7:0]) || dataLastIn) begin
                        doDrop = 1'b1;
                    end else if (hdrIdx == ETH_HDR_LEN - 6'd1) begin
                        stateD   = StIpHdr;
                        byteCntD = 6'd0;
                    end
                end
                StIpHdr: begin
                    byteCntD = byteCntQ + 6'd1;
                    if ((byteCntQ == 6'd0 && dataIn != IP_VER_IHL) ||
                        (byteCntQ == 6'd9 && dataIn != IP_PROTO_UDP) || dataLastIn) begin
                        doDrop = 1'b1;
                    end else if (byteCntQ == IP_HDR_LEN - 6'd1) begin
                        stateD   = StUdpHdr;
                        byteCntD = 6'd0;
                    end
                end
                StUdpHdr: begin
                    byteCntD = byteCntQ + 6'd1;
                    if ((byteCntQ == 6'd2 && dataIn != UDP_PORT[15:8]) ||
                        (byteCntQ == 6'd3 && dataIn != UDP_PORT[7:0]) || dataLastIn) begin
                        doDrop = 1'b1;
                    end else if (byteCntQ == UDP_HDR_LEN - 6'd1) begin
                        stateD   = StMoldHdr;
                        byteCntD = 6'd0;
                    end
                end
                StMoldHdr: begin
                    byteCntD = byteCntQ + 6'd1;
                    if (byteCntQ >= 6'd10 && byteCntQ < 6'd18) begin
                        seqShD = {seqShQ[55:0], dataIn};
                    end
                    if (byteCntQ == 6'd18) begin
                        fieldHiD = dataIn;
                    end
                    if (byteCntQ == MOLD_HDR_LEN - 6'd1) begin
                        if (expValidQ && seqShQ != expSeqQ) begin
                            seqGapD = 1'b1;
                        end
                        expSeqD    = seqShQ + ((fieldWord == MOLD_EOS_CNT) ? 64'd0
                                                                        : {48'd0, fieldWord});
                        expValidD  = 1'b1;
                        msgRemainD = fieldWord;
                        curSeqD    = seqShQ;
                        msgSeenD   = 1'b0;
                        if (fieldWord == 16'd0) begin
                            stateD = dataLastIn ? StIdle : StDrain;
                        end else if (fieldWord == MOLD_EOS_CNT) begin
                            eosD   = 1'b1;
                            stateD = dataLastIn ? StIdle : StDrain;
                        end else if (dataLastIn) begin
                            doDrop = 1'b1;
                        end else begin
                            stateD = StLenHi;
                        end
                    end else if (dataLastIn) begin
                        doDrop = 1'b1;
                    end
                end
                StLenHi: begin
                    fieldHiD = dataIn;
                    if (dataLastIn) begin
                        stateD = StIdle;
                        doDrop = !msgSeenQ;
                    end else begin
                        stateD = StLenLo;
                    end
                end
                StLenLo: begin
                    if (fieldWord == 16'd0) begin
                        msgRemainD = remainDec;
                        curSeqD    = curSeqQ + 64'd1;
                        if (remainDec == 16'd0) begin
                            stateD = dataLastIn ? StIdle : StDrain;
                        end else if (dataLastIn) begin
                            stateD = StIdle;
                            doDrop = !msgSeenQ;
                        end else begin
                            stateD = StLenHi;
                        end
                    end else if (dataLastIn) begin
                        // Once any message of this frame went out, a short tail is not a drop.
                        stateD = StIdle;
                        doDrop = !msgSeenQ;
                    end else begin
                        bodyRemD = fieldWord;
                        firstD   = 1'b1;
                        stateD   = StMsgBody;
                    end
                end
                StMsgBody: begin
                    msgDataD  = dataIn;
                    msgValidD = 1'b1;
                    msgStartD = firstQ;
                    firstD    = 1'b0;
                    seqNumD   = curSeqQ;
                    msgSeenD  = 1'b1;
                    bodyRemD  = bodyRemQ - 16'd1;
                    if (bodyRemQ == 16'd1) begin
                        msgEndD    = 1'b1;
                        curSeqD    = curSeqQ + 64'd1;
                        msgRemainD = remainDec;
                        if (dataLastIn) begin
                            stateD = StIdle;
                        end else begin
                            stateD = (remainDec == 16'd0) ? StDrain : StLenHi;
                        end
                    end else if (dataLastIn) begin
                        msgEndD = 1'b1;
                        msgErrD = 1'b1;
                        stateD  = StIdle;
                    end
                end
                StDrain: begin
                    if (dataLastIn) begin
                        stateD = StIdle;
                    end
                end
                default: begin
                    stateD = StIdle;
                end
            endcase

            if (doDrop) begin
                dropCntD = dropCntQ + CNT_W'(1);
                stateD   = dataLastIn ? StIdle : StDrain;
            end
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            stateQ     <= StIdle;
            byteCntQ   <= '0;
            seqShQ     <= '0;
            fieldHiQ   <= '0;
            expSeqQ    <= '0;
            expValidQ  <= 1'b0;
            curSeqQ    <= '0;
            msgRemainQ <= '0;
            bodyRemQ   <= '0;
            firstQ     <= 1'b0;
            msgSeenQ   <= 1'b0;
            msgDataQ   <= '0;
            msgValidQ  <= 1'b0;
            msgStartQ  <= 1'b0;
            msgEndQ    <= 1'b0;
            msgErrQ    <= 1'b0;
            seqNumQ    <= '0;
            seqGapQ    <= 1'b0;
            eosQ       <= 1'b0;
            dropCntQ   <= '0;
        end else begin
            stateQ     <= stateD;
            byteCntQ   <= byteCntD;
            seqShQ     <= seqShD;
            fieldHiQ   <= fieldHiD;
            expSeqQ    <= expSeqD;
            expValidQ  <= expValidD;
            curSeqQ    <= curSeqD;
            msgRemainQ <= msgRemainD;
            bodyRemQ   <= bodyRemD;
            firstQ     <= firstD;
            msgSeenQ   <= msgSeenD;
            msgDataQ   <= msgDataD;
            msgValidQ  <= msgValidD;
            msgStartQ  <= msgStartD;
            msgEndQ    <= msgEndD;
            msgErrQ    <= msgErrD;
            seqNumQ    <= seqNumD;
            seqGapQ    <= seqGapD;
            eosQ       <= eosD;
            dropCntQ   <= dropCntD;
        end
    end

    assign msgDataOut  = msgDataQ;
    assign msgValidOut = msgValidQ;
    assign msgStartOut = msgStartQ;
    assign msgEndOut   = msgEndQ;
    assign msgErrOut   = msgErrQ;
    assign seqNumOut   = seqNumQ;
    assign seqGapOut   = seqGapQ;
    assign eosOut      = eosQ;
    assign dropCntOut  = dropCntQ;

endmodule

// File: tb/tb_moldudp64_rx_parser.sv
// Randomized bench: frames are built byte-wise, a frame-level model predicts
// messages, gaps, end-of-session pulses and drops.
module tb_moldudp64_rx_parser;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [7:0]  dataIn;
    logic        dataValidIn;
    logic        dataLastIn;
    logic [7:0]  msgDataOut;
    logic        msgValidOut;
    logic        msgStartOut;
    logic        msgEndOut;
    logic        msgErrOut;
    logic [63:0] seqNumOut;
    logic        seqGapOut;
    logic        eosOut;
    logic [15:0] dropCntOut;

    moldudp64_rx_parser #(
        .UDP_PORT(16'd26400),
        .CNT_W   (16)
    ) dut (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .dataIn     (dataIn),
        .dataValidIn(dataValidIn),
        .dataLastIn (dataLastIn),
        .msgDataOut (msgDataOut),
        .msgValidOut(msgValidOut),
        .msgStartOut(msgStartOut),
        .msgEndOut  (msgEndOut),
        .msgErrOut  (msgErrOut),
        .seqNumOut  (seqNumOut),
        .seqGapOut  (seqGapOut),
        .eosOut     (eosOut),
        .dropCntOut (dropCntOut)
    );

    always #2 clkIn = ~clkIn;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0]  frm[$];
    logic [15:0] lenQ[$];
    logic [74:0] expQ[$];

    logic [63:0] mExpSeq   = '0;
    bit          mExpValid = 0;
    logic [15:0] mDrop     = '0;
    int          mGap      = 0;
    int          mEos      = 0;

    bit          monOn   = 1;
    int          nOut    = 0;
    int          gapSeen = 0;
    int          eosSeen = 0;
    logic [74:0] monExp;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [15:0] etype, input logic [7:0] ihl, input logic [7:0] proto,
                         input logic [15:0] port, input logic [63:0] seq, input logic [15:0] cnt,
                         input int pad);
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        frm.push_back(ihl);
        for (int i = 1; i < 9; i++) frm.push_back(8'($urandom));
        frm.push_back(proto);
        for (int i = 10; i < 20; i++) frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
        frm.push_back(port[15:8]);
        frm.push_back(port[7:0]);
        for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
        for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
        for (int i = 7; i >= 0; i--) frm.push_back(seq[i*8 +: 8]);
        frm.push_back(cnt[15:8]);
        frm.push_back(cnt[7:0]);
        foreach (lenQ[j]) begin
            frm.push_back(lenQ[j][15:8]);
            frm.push_back(lenQ[j][7:0]);
            for (int k = 0; k < int'(lenQ[j]); k++) frm.push_back(8'($urandom));
        end
        for (int i = 0; i < pad; i++) frm.push_back(8'($urandom));
    endtask

    task automatic trunc(input int n);
        while (frm.size() > n) void'(frm.pop_back());
    endtask

    // Frame layout: eth 0-13, ip 14-33, udp 34-41, mold 42-61 (seq 52-59, count 60-61).
    task automatic modelFrame();
        int          n;
        int          pos;
        logic [63:0] sq;
        logic [63:0] cur;
        logic [15:0] cnt;
        logic [15:0] len;
        bit          seen;
        bit          last;
        bit          trn;
        n    = frm.size();
        seen = 0;
        sq   = '0;
        if ((n > 12 && frm[12] != 8'h08) || (n > 13 && frm[13] != 8'h00) ||
            (n > 14 && frm[14] != 8'h45) || (n > 23 && frm[23] != 8'h11) ||
            (n > 36 && frm[36] != 8'h67) || (n > 37 && frm[37] != 8'h20) || n < 62) begin
            mDrop = mDrop + 16'd1;
            return;
        end
        for (int i = 0; i < 8; i++) sq = {sq[55:0], frm[52+i]};
        cnt = {frm[60], frm[61]};
        if (mExpValid && sq != mExpSeq) mGap++;
        mExpSeq   = sq + ((cnt == 16'hFFFF) ? 64'd0 : 64'(cnt));
        mExpValid = 1;
        if (cnt == 16'd0) return;
        if (cnt == 16'hFFFF) begin
            mEos++;
            return;
        end
        if (n == 62) begin
            mDrop = mDrop + 16'd1;
            return;
        end
        cur = sq;
        pos = 62;
        for (int m = 0; m < int'(cnt); m++) begin
            if (pos == n) return;
            if (pos + 2 > n) begin
                if (!seen) mDrop = mDrop + 16'd1;
                return;
            end
            len = {frm[pos], frm[pos+1]};
            pos += 2;
            if (len == 16'd0) begin
                cur = cur + 64'd1;
                if (pos == n && m + 1 < int'(cnt)) begin
                    if (!seen) mDrop = mDrop + 16'd1;
                    return;
                end
                continue;
            end
            if (pos == n) begin
                if (!seen) mDrop = mDrop + 16'd1;
                return;
            end
            for (int k = 0; k < int'(len); k++) begin
                last = (k == int'(len) - 1);
                trn  = !last && (pos == n - 1);
                expQ.push_back({cur, frm[pos], k == 0, last || trn, trn});
                seen = 1;
                pos++;
                if (trn) return;
            end
            cur = cur + 64'd1;
        end
    endtask

    task automatic send(input int stallPct, input int nSend);
        for (int i = 0; i < nSend; i++) begin
            while (int'($urandom_range(99)) < stallPct) begin
                dataValidIn = 1'b0;
                dataLastIn  = 1'b0;
                @(posedge clkIn);
                #1;
            end
            dataIn      = frm[i];
            dataValidIn = 1'b1;
            dataLastIn  = (i == frm.size() - 1);
            @(posedge clkIn);
            #1;
        end
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
    endtask

    task automatic groupCheck(input string tag);
        repeat (4) @(posedge clkIn);
        #1;
        chk({tag, " pending"}, expQ.size(), 0);
        chk({tag, " gaps"}, gapSeen, mGap);
        chk({tag, " eos"}, eosSeen, mEos);
        chk({tag, " drops"}, dropCntOut, mDrop);
    endtask

    always @(negedge clkIn) begin
        if (!rstIn && monOn) begin
            if (seqGapOut) gapSeen++;
            if (eosOut) eosSeen++;
            if (msgValidOut) begin
                nOut++;
                if (expQ.size() == 0) begin
                    chk("extra byte", {seqNumOut, msgDataOut}, 0);
                end else begin
                    monExp = expQ.pop_front();
                    chk("msg byte", {seqNumOut, msgDataOut, msgStartOut, msgEndOut, msgErrOut},
                        monExp);
                end
            end else if (msgStartOut || msgEndOut || msgErrOut) begin
                chk("flags without valid", {msgStartOut, msgEndOut, msgErrOut}, 0);
            end
        end
    end

    int          n0, g0, e0;
    logic [15:0] d0;
    int unsigned r;
    logic [15:0] et, po, cntR;
    logic [7:0]  ih, pr;
    logic [63:0] sqR;

    initial begin
        rstIn       = 1'b1;
        dataIn      = '0;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        repeat (3) @(posedge clkIn);
        #1;
        rstIn = 1'b0;
        chk("reset valid", {msgValidOut, msgStartOut, msgEndOut, msgErrOut}, 0);
        chk("reset data", msgDataOut, 0);
        chk("reset seq", seqNumOut, 0);
        chk("reset pulses", {seqGapOut, eosOut}, 0);
        chk("reset drops", dropCntOut, 0);

        // Basic frame: seq 100, two messages of 3 and 1 bytes.
        n0 = nOut;
        lenQ = {16'd3, 16'd1};
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd100, 16'd2, 4);
        modelFrame();
        send(0, frm.size());
        groupCheck("basic");
        chk("basic byte count", nOut - n0, 4);

        // Same shape with heavy stalls; seq 102 continues without a gap.
        n0 = nOut;
        g0 = gapSeen;
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd102, 16'd2, 4);
        modelFrame();
        send(50, frm.size());
        groupCheck("stall");
        chk("stall byte count", nOut - n0, 4);
        chk("stall no gap", gapSeen - g0, 0);

        // Gap: 104/count 2 is in order, then 109 instead of 106.
        g0 = gapSeen;
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd104, 16'd2, 0);
        modelFrame();
        send(0, frm.size());
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd109, 16'd2, 2);
        modelFrame();
        send(0, frm.size());
        groupCheck("gap");
        chk("gap pulses", gapSeen - g0, 1);

        // Filter rejects.
        n0 = nOut;
        d0 = dropCntOut;
        build(16'h86DD, 8'h45, 8'h11, 16'd26400, 64'd111, 16'd2, 0);
        modelFrame();
        send(0, frm.size());
        build(16'h0800, 8'h45, 8'h11, 16'd26401, 64'd111, 16'd2, 0);
        modelFrame();
        send(0, frm.size());
        build(16'h0800, 8'h46, 8'h11, 16'd26400, 64'd111, 16'd2, 0);
        modelFrame();
        send(0, frm.size());
        groupCheck("filter");
        chk("filter no output", nOut - n0, 0);
        chk("filter drop delta", dropCntOut - d0, 3);

        // Heartbeat then end-of-session.
        n0 = nOut;
        d0 = dropCntOut;
        e0 = eosSeen;
        lenQ.delete();
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd111, 16'd0, 6);
        modelFrame();
        send(0, frm.size());
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd111, 16'hFFFF, 6);
        modelFrame();
        send(30, frm.size());
        groupCheck("eos");
        chk("eos no output", nOut - n0, 0);
        chk("eos pulses", eosSeen - e0, 1);
        chk("eos drop delta", dropCntOut - d0, 0);

        // Truncated message: length 10, frame ends after 4 payload bytes.
        n0 = nOut;
        lenQ = {16'd10};
        build(16'h0800, 8'h45, 8'h11, 16'd26400, mExpSeq, 16'd1, 0);
        trunc(68);
        modelFrame();
        send(0, frm.size());
        lenQ = {16'd2, 16'd5};
        build(16'h0800, 8'h45, 8'h11, 16'd26400, mExpSeq, 16'd2, 0);
        modelFrame();
        send(0, frm.size());
        groupCheck("trunc");
        chk("trunc byte count", nOut - n0, 11);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            r  = $urandom_range(99);
            et = 16'h0800;
            ih = 8'h45;
            pr = 8'h11;
            po = 16'd26400;
            if (r < 4) et = 16'h86DD;
            else if (r < 7) ih = 8'h46;
            else if (r < 9) pr = 8'h06;
            else if (r < 11) po = 16'd26401;
            cntR = 16'($urandom_range(4));
            if ($urandom_range(19) == 0) cntR = 16'hFFFF;
            lenQ.delete();
            if (cntR != 16'hFFFF) begin
                for (int i = 0; i < int'(cntR); i++) lenQ.push_back(16'($urandom_range(6)));
            end
            sqR = ($urandom_range(9) < 7) ? mExpSeq : {$urandom, $urandom};
            build(et, ih, pr, po, sqR, cntR, int'($urandom_range(5)));
            if ($urandom_range(99) < 15) trunc(1 + int'($urandom_range(frm.size() - 1)));
            modelFrame();
            send(30, frm.size());
            groupCheck("random");
        end

        // Reset in the middle of a message body.
        monOn = 0;
        lenQ = {16'd20};
        build(16'h0800, 8'h45, 8'h11, 16'd26400, mExpSeq, 16'd1, 0);
        send(0, 70);
        rstIn = 1'b1;
        @(negedge clkIn);
        chk("midrst valid", {msgValidOut, msgStartOut, msgEndOut, msgErrOut}, 0);
        chk("midrst data", msgDataOut, 0);
        chk("midrst seq", seqNumOut, 0);
        chk("midrst pulses", {seqGapOut, eosOut}, 0);
        chk("midrst drops", dropCntOut, 0);
        @(posedge clkIn);
        #1;
        rstIn     = 1'b0;
        mExpValid = 0;
        mDrop     = '0;
        expQ.delete();
        monOn     = 1;
        n0        = nOut;
        lenQ = {16'd2, 16'd3};
        build(16'h0800, 8'h45, 8'h11, 16'd26400, 64'd77, 16'd2, 3);
        modelFrame();
        send(50, frm.size());
        groupCheck("postrst");
        chk("postrst byte count", nOut - n0, 5);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/moldudp64_rx_parser.md
# moldudp64_rx_parser

Sequences the 250 MHz receive byte stream after the rxClkLcl→clk250 CDC FIFO. It walks Ethernet/IPv4/UDP/MoldUDP64 headers and filters non-matching frames. It then splits the MoldUDP64 payload into individual messages, each tagged with its sequence number, for the downstream book builder. It is the stream controller that fills the header-parser slot of ethernet_to_book_top.

## Interface
Parameters:
- UDP_PORT, 16'd26400, accepted UDP destination port
- CNT_W, 16, width of the drop counter

Ports:
- clkIn  in  1  clk250 domain clock
- rstIn  in  1  reset; asynchronous, active-high
- dataIn  in  8  frame byte; the first byte is the destination MAC (preamble/SFD already stripped)
- dataValidIn  in  1  dataIn valid; low = stall, no state change
- dataLastIn  in  1  last byte of frame (qualified by dataValidIn)
- msgDataOut  out  8  message payload byte
- msgValidOut  out  1  msgDataOut valid
- msgStartOut  out  1  first byte of message
- msgEndOut  out  1  last byte of message
- msgErrOut  out  1  with msgEndOut: message truncated by end of frame
- seqNumOut  out  64  sequence number of current message, stable while msgValidOut
- seqGapOut  out  1  one-cycle pulse: frame sequence number ≠ expected
- eosOut  out  1  one-cycle pulse: end-of-session frame (count 0xFFFF)
- dropCntOut  out  CNT_W  frames rejected, wraps

## Operation
- States: IDLE, ETH_HDR, IP_HDR, UDP_HDR, MOLD_HDR, LEN_HI, LEN_LO, MSG_BODY, DRAIN. A 6-bit byte counter runs within each header state.
- IDLE: the first valid byte enters ETH_HDR (byte 0).
- ETH_HDR, 14 B: bytes 12–13 must be 0x0800. Otherwise DRAIN and dropCnt+1.
- IP_HDR, 20 B: byte 0 must be 0x45 (no options) and byte 9 must be 0x11. Otherwise DRAIN and drop.
- UDP_HDR, 8 B: bytes 2–3 must equal UDP_PORT. Otherwise DRAIN and drop.
- MOLD_HDR, 20 B: session (10 B, ignored), seq (8 B, big-endian), count (2 B).
  - On the last header byte, check seq: if expValid and seq ≠ expSeq, pulse seqGapOut. Then set expSeq = seq + count (count 0xFFFF adds 0) and expValid = 1.
  - count = 0 (heartbeat): DRAIN.
  - count = 0xFFFF: pulse eosOut, DRAIN.
  - Otherwise: LEN_HI, msgRemain = count, curSeq = seq.
- LEN_HI/LEN_LO: capture the 16-bit message length.
  - Length 0: no output; decrement msgRemain and curSeq+1; next LEN_HI, or DRAIN if msgRemain reaches 0.
  - Otherwise: MSG_BODY.
- MSG_BODY: forward bytes.
  - On the last byte: msgEndOut, curSeq+1, msgRemain−1, then LEN_HI or DRAIN.
- DRAIN: discard bytes until dataLastIn, then IDLE. Trailing padding/FCS is not an error.
- dataLastIn in any header/LEN state before completion: drop (dropCnt+1), IDLE.
- dataLastIn in MSG_BODY before the length is exhausted: that byte is output with msgEndOut=1 and msgErrOut=1, then IDLE.
- dataLastIn coinciding with a regular message end: normal msgEndOut, then IDLE.
- A drop and a message are never reported for the same frame once MOLD_HDR has completed.

## Timing
- All outputs are registered. A byte accepted at cycle t appears on msgDataOut at t+1.
- seqGapOut/eosOut assert at t+1 after the last MOLD_HDR byte.
- A one-byte message asserts msgStartOut and msgEndOut together.
- Throughput is 1 byte/cycle. There is no backpressure; downstream must always accept.
- Reset values: all outputs 0, seqNumOut 0, dropCntOut 0, state IDLE, expValid 0.
- Reset mid-frame returns to IDLE. The upstream FIFO shares rst250, so the next byte is a frame start.
- Arithmetic: expSeq and curSeq are 64-bit and wrap modulo 2^64. msgRemain is 16-bit. Lengths are unsigned 16-bit.

## Structure
- pkg.sv holds:
  - the state enum rx_parser_state_t
  - ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, MOLD_HDR_LEN=20
  - ETHERTYPE_IPV4=16'h0800, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, MOLD_EOS_CNT=16'hFFFF
- Single module with no sub-module. The FSM, field capture shift registers and counters all live in one always_ff / always_comb pair.

## Test plan
- Valid frame, port 26400, seq 100, count 2, lengths 3 and 1 → 4 valid bytes; seqNumOut 100 for 3 bytes, then 101 with start+end together; expSeq 102.
- Two frames with seq 100/count 2 then seq 105 → seqGapOut pulses once on the second frame; messages are still forwarded with seq 105.
- Ethertype 0x86DD, then UDP port 26401, then IHL 0x46 → no msgValidOut; dropCntOut = 3.
- Count 0 frame, then count 0xFFFF frame → no messages; eosOut pulses once; dropCntOut unchanged.
- Frame declaring length 10 but ending after 4 payload bytes → 4 bytes out; the last has msgEndOut=1, msgErrOut=1; the next frame parses normally.
- Random dataValidIn stalls (50%) on the first test → identical output sequence; rstIn asserted mid-MSG_BODY → all outputs 0 next edge, next frame parsed.
